// File: rtl/sprite_ram_loader_if.sv
// ---------------------------------------------------------------------------
// sprite_ram_loader_if
// Bundles the nibble-stream handshake, load status and read port of the
// sprite RAM loader into one interface.
//   master : the host side (drives start / nibbles / read address)
//   slave  : the loader side (drives ready / status / read data / checksum)
// Signals:
//   start     one-cycle pulse that begins (or restarts) a load at address 0
//   in_data   next IW-bit nibble, first nibble of a word is its MSB
//   in_valid  in_data is valid
//   in_ready  loader accepts a nibble this cycle
//   busy      a load is in progress
//   done      one-cycle pulse after the final word is written
//   wr_count  words written in the current or last load (AW+1 bits)
//   rd_addr   read address
//   rd_data   registered read data (1-cycle latency)
//   checksum  running sum of written words (0 when the feature is off)
// ---------------------------------------------------------------------------
interface sprite_ram_loader_if #(
   parameter int AW = 10,
   parameter int DW = 12,
   parameter int IW = 4
);
   logic          start;
   logic [IW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          busy;
   logic          done;
   logic [AW:0]   wr_count;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] checksum;

   modport master (
      output start, in_data, in_valid, rd_addr,
      input  in_ready, busy, done, wr_count, rd_data, checksum
   );

   modport slave (
      input  start, in_data, in_valid, rd_addr,
      output in_ready, busy, done, wr_count, rd_data, checksum
   );
endinterface

// File: rtl/sprite_ram_loader.sv
// ---------------------------------------------------------------------------
// sprite_ram_loader
// Packs a stream of IW-bit hex nibbles into DW-bit words and writes them
// sequentially into an implied block RAM of 2**AW words. A registered read
// port (1-cycle latency, read-before-write) serves the VGA sprite path, so
// sprites can be reloaded at runtime.
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   asynchronous reset, active low
//   io_bus  sprite_ram_loader_if.slave (handshake, status, read port)
// Parameters:
//   AW  address width (depth 2**AW)
//   DW  word width, an integer multiple of IW
//   IW  nibble width
// Optional feature:
//   SPRITE_LOADER_CHECKSUM_EN  when defined, io_bus.checksum accumulates the
//   written words modulo 2**DW; otherwise it is tied to 0.
// ---------------------------------------------------------------------------
module sprite_ram_loader #(
   parameter int AW = 10,
   parameter int DW = 12,
   parameter int IW = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   sprite_ram_loader_if.slave io_bus
);

   localparam int NPW   = DW / IW;                      // nibbles per word
   localparam int NCW   = (NPW > 1) ? $clog2(NPW) : 1;  // nibble counter width
   localparam int DEPTH = 2 ** AW;

   localparam logic [NCW-1:0] NIB_LAST = NCW'(NPW - 1);
   localparam logic [NCW-1:0] NIB_ONE  = NCW'(1);
   localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_done;
   logic           w_done_nxt;

   logic           w_load;
   logic           w_accept;
   logic           w_word_end;
   logic           w_last_word;
   logic [DW-1:0]  w_word;

   logic [NCW-1:0] r_nib_cnt;
   logic [DW-1:0]  r_pack;
   logic [AW:0]    r_wr_count;
   logic [DW-1:0]  r_rd_data;
   logic [DW-1:0]  r_mem [DEPTH];

   assign w_load = (r_state == LOAD);

   // start has priority: a nibble presented on the same edge is dropped.
   assign w_accept   = io_bus.in_valid && w_load && !io_bus.start;
   assign w_word_end = w_accept && (r_nib_cnt == NIB_LAST);

   // Completed word including the nibble being accepted now, so the RAM write
   // happens on the same edge as the last nibble.
   assign w_word = (r_pack << IW) | DW'(io_bus.in_data);

   // In LOAD wr_count never exceeds DEPTH-1, so all-ones low bits mean this
   // write fills the last address.
   assign w_last_word = (r_wr_count[AW-1:0] == '1);

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------
   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (io_bus.start) w_state_nxt = LOAD;
         end
         LOAD: begin
            if (io_bus.start) begin
               w_state_nxt = LOAD;                 // abort and restart
            end else if (w_word_end && w_last_word) begin
               w_state_nxt = DONE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Packing datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_nib_cnt  <= '0;
         r_pack     <= '0;
         r_wr_count <= '0;
      end else if (io_bus.start) begin
         r_nib_cnt  <= '0;
         r_pack     <= '0;
         r_wr_count <= '0;
      end else if (w_accept) begin
         r_pack <= w_word;
         if (w_word_end) begin
            r_nib_cnt  <= '0;
            r_wr_count <= r_wr_count + CNT_ONE;
         end else begin
            r_nib_cnt  <= r_nib_cnt + NIB_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Block RAM: write port plus registered read port
   // ---------------------------------------------------------------------
   // NOTE: the array has no reset so it maps onto block RAM; sprites loaded
   // before a reset stay readable afterwards.
   always_ff @(posedge i_clk) begin
      if (w_word_end) r_mem[r_wr_count[AW-1:0]] <= w_word;
   end

   // Reading the array on the same edge as the write returns the old word.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_rd_data <= '0;
      else        r_rd_data <= r_mem[io_bus.rd_addr];
   end

   // ---------------------------------------------------------------------
   // Optional checksum
   // ---------------------------------------------------------------------
`ifdef SPRITE_LOADER_CHECKSUM_EN
   logic [DW-1:0] r_checksum;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)              r_checksum <= '0;
      else if (io_bus.start)   r_checksum <= '0;
      else if (w_word_end)     r_checksum <= r_checksum + w_word;
   end

   assign io_bus.checksum = r_checksum;
`else
   assign io_bus.checksum = '0;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign io_bus.in_ready = w_load;
   assign io_bus.busy     = w_load;
   assign io_bus.done     = r_done;
   assign io_bus.wr_count = r_wr_count;
   assign io_bus.rd_data  = r_rd_data;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_sprite_ram_loader
// Directed bench for sprite_ram_loader with AW=2, DW=8, IW=4. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sprite_ram_loader;

   localparam int AW = 2;
   localparam int DW = 8;
   localparam int IW = 4;

`ifdef SPRITE_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   sprite_ram_loader_if #(.AW(AW), .DW(DW), .IW(IW)) bus ();

   sprite_ram_loader #(.AW(AW), .DW(DW), .IW(IW)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and count done pulses seen there.
   task automatic tick();
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Stream n nibbles taken MSB-first from nibs; gap inserts an idle cycle
   // (in_valid low) before every nibble except the first.
   task automatic stream(input logic [31:0] nibs, input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         if (gap && i > 0) begin
            bus.in_valid = 1'b0;
            tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = nibs[31-4*i -: 4];
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   // Read all four words; exp holds address 0 in its top byte.
   task automatic check_mem(input string tag, input logic [31:0] exp);
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = AW'(a);
         tick();
         check($sformatf("%s_mem%0d", tag, a), 32'(bus.rd_data), 32'(exp[31-8*a -: 8]));
      end
   endtask

   // Checks that directly follow the edge of the final write.
   task automatic check_end(input string tag);
      check({tag, "_done"},     32'(bus.done),     32'd1);
      check({tag, "_busy"},     32'(bus.busy),     32'd0);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_wr_count"}, 32'(bus.wr_count), 32'd4);
      tick();
      check({tag, "_done_low"}, 32'(bus.done),     32'd0);
      check({tag, "_done_cnt"}, 32'(done_cnt),     32'd1);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.rd_addr  = '0;

      // ---------------- reset ----------------
      #1 rst = 1'b0;
      #2;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_busy",     32'(bus.busy),     32'd0);
      check("rst_done",     32'(bus.done),     32'd0);
      check("rst_wr_count", 32'(bus.wr_count), 32'd0);
      check("rst_rd_data",  32'(bus.rd_data),  32'd0);
      check("rst_checksum", 32'(bus.checksum), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);

      // ---------------- scenario 1: basic load ----------------
      done_cnt = 0;
      pulse_start();
      check("s1_busy_after_start",  32'(bus.busy),     32'd1);
      check("s1_ready_after_start", 32'(bus.in_ready), 32'd1);
      stream(32'h1234_5678, 8, 1'b0);
      check_end("s1");
      check("s1_checksum", 32'(bus.checksum), CSUM_EN ? 32'h14 : 32'h0);
      check_mem("s1", 32'h1234_5678);
      bus.rd_addr = 2'd2;
      tick();
      check("s1_read_addr2", 32'(bus.rd_data), 32'h56);

      // ---------------- scenario 2: nibbles outside LOAD ignored ----------------
      bus.in_valid = 1'b1;
      bus.in_data  = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("s2_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      check("s2_wr_count", 32'(bus.wr_count), 32'd4);
      check_mem("s2", 32'h1234_5678);

      // ---------------- scenario 3: restart mid-load ----------------
      done_cnt = 0;
      pulse_start();
      stream(32'h1230_0000, 3, 1'b0);
      check("s3_wr_count_partial", 32'(bus.wr_count), 32'd1);
      // start together with a valid nibble: start wins, nibble dropped
      bus.start    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 4'h4;
      tick();
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      check("s3_wr_count_restart", 32'(bus.wr_count), 32'd0);
      check("s3_busy_restart",     32'(bus.busy),     32'd1);
      stream(32'h9ABC_DEF0, 8, 1'b0);
      check_end("s3");
      check("s3_checksum", 32'(bus.checksum), CSUM_EN ? 32'h24 : 32'h0);
      check_mem("s3", 32'h9ABC_DEF0);

      // ---------------- scenario 4: in_valid toggling ----------------
      done_cnt = 0;
      pulse_start();
      stream(32'h1234_5678, 8, 1'b1);
      check_end("s4");
      check("s4_checksum", 32'(bus.checksum), CSUM_EN ? 32'h14 : 32'h0);
      check_mem("s4", 32'h1234_5678);

      // ---------------- scenario 5: async reset mid-word ----------------
      pulse_start();
      stream(32'hABCD_E000, 5, 1'b0);
      check("s5_wr_count_before", 32'(bus.wr_count), 32'd2);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'h7;
      #2 rst = 1'b0;
      #1;
      check("s5_rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("s5_rst_busy",     32'(bus.busy),     32'd0);
      check("s5_rst_done",     32'(bus.done),     32'd0);
      check("s5_rst_wr_count", 32'(bus.wr_count), 32'd0);
      check("s5_rst_rd_data",  32'(bus.rd_data),  32'd0);
      check("s5_rst_checksum", 32'(bus.checksum), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("s5_idle_in_ready", 32'(bus.in_ready), 32'd0);
      check("s5_idle_wr_count", 32'(bus.wr_count), 32'd0);
      bus.in_valid = 1'b0;
      check_mem("s5", 32'hABCD_5678);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
